chain_mixer_seq: RTL and testbench



---
 rtl/chain_mixer_seq.sv | 155 +++++++++++++++
 tb/tb_chain_mixer_seq.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chain_mixer_seq.sv
// Sequencer for a chain of NUM_STAGES two-input mixers: per stage load reagent, mix, transfer downstream.
// Optional abort input/aborted flag enabled by defining CHAIN_MIXER_SEQ_ABORT_EN.
module chain_mixer_seq #(
    parameter int NUM_STAGES  = 96,
    parameter int CNT_W       = 16,
    parameter int LOAD_CYCLES = 8,
    parameter int XFER_CYCLES = 4,
    localparam int STAGE_W    = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [CNT_W-1:0]      mix_cycles,
    input  logic [NUM_STAGES-1:0] skip_mask,
`ifdef CHAIN_MIXER_SEQ_ABORT_EN
    input  logic                  abort,
    output logic                  aborted,
`endif
    output logic                  ready,
    output logic                  busy,
    output logic                  done,
    output logic [STAGE_W-1:0]    stage,
    output logic [NUM_STAGES-1:0] load_valve,
    output logic [NUM_STAGES-1:0] mix_en,
    output logic [NUM_STAGES-1:0] xfer_valve
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_MIX,
        S_XFER,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0]   LOAD_INIT  = CNT_W'(LOAD_CYCLES - 1);
    localparam logic [CNT_W-1:0]   XFER_INIT  = CNT_W'(XFER_CYCLES - 1);
    localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(NUM_STAGES - 1);

    state_t                  state;
    logic [CNT_W-1:0]        cnt;
    logic [CNT_W-1:0]        mix_q;
    logic [NUM_STAGES-1:0]   skip_q;
    logic [STAGE_W-1:0]      stage_nxt;
    logic [NUM_STAGES-1:0]   stage_onehot;
    logic                    cnt_zero;
    logic                    running;

    assign stage_nxt    = stage + STAGE_W'(1);
    assign stage_onehot = NUM_STAGES'(1) << stage;
    assign cnt_zero     = (cnt == '0);
    assign running      = (state == S_LOAD) || (state == S_MIX) || (state == S_XFER);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            stage  <= '0;
            cnt    <= '0;
            mix_q  <= '0;
            skip_q <= '0;
`ifdef CHAIN_MIXER_SEQ_ABORT_EN
            aborted <= 1'b0;
`endif
        end else begin
`ifdef CHAIN_MIXER_SEQ_ABORT_EN
            // Abort wins over any counter expiry in the same cycle.
            if (abort && running) begin
                state   <= S_IDLE;
                stage   <= '0;
                cnt     <= '0;
                aborted <= 1'b1;
            end else begin
`endif
            case (state)
                S_IDLE: begin
                    stage <= '0;
                    if (start) begin
                        mix_q  <= mix_cycles;
                        skip_q <= skip_mask;
`ifdef CHAIN_MIXER_SEQ_ABORT_EN
                        aborted <= 1'b0;
`endif
                        if (skip_mask[0]) begin
                            state <= S_XFER;
                            cnt   <= XFER_INIT;
                        end else begin
                            state <= S_LOAD;
                            cnt   <= LOAD_INIT;
                        end
                    end
                end
                S_LOAD: begin
                    if (cnt_zero) begin
                        if (mix_q == '0) begin
                            state <= S_XFER;
                            cnt   <= XFER_INIT;
                        end else begin
                            state <= S_MIX;
                            cnt   <= mix_q - CNT_W'(1);
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                S_MIX: begin
                    if (cnt_zero) begin
                        state <= S_XFER;
                        cnt   <= XFER_INIT;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                S_XFER: begin
                    if (cnt_zero) begin
                        if (stage == LAST_STAGE) begin
                            state <= S_DONE;
                        end else begin
                            stage <= stage_nxt;
                            if (skip_q[stage_nxt]) begin
                                state <= S_XFER;
                                cnt   <= XFER_INIT;
                            end else begin
                                state <= S_LOAD;
                                cnt   <= LOAD_INIT;
                            end
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    stage <= '0;
                end
                default: begin
                    state <= S_IDLE;
                    stage <= '0;
                    cnt   <= '0;
                end
            endcase
`ifdef CHAIN_MIXER_SEQ_ABORT_EN
            end
`endif
        end
    end

    // Outputs are pure decodes of registered state, so no input reaches an output in the same cycle.
    assign ready      = (state == S_IDLE);
    assign busy       = running;
    assign done       = (state == S_DONE);
    assign load_valve = (state == S_LOAD) ? stage_onehot : '0;
    assign mix_en     = (state == S_MIX)  ? stage_onehot : '0;
    assign xfer_valve = (state == S_XFER) ? stage_onehot : '0;

endmodule

// File: tb/tb_chain_mixer_seq.sv
// Directed self-checking bench for chain_mixer_seq with NUM_STAGES=4, LOAD=2, XFER=1.
// Traces are captured per cycle (cycle 1 = cycle after the start edge) and checked against hand timelines.
module tb_chain_mixer_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] mix_cycles;
    logic [3:0]  skip_mask;
    logic        ready;
    logic        busy;
    logic        done;
    logic [1:0]  stage;
    logic [3:0]  load_valve;
    logic [3:0]  mix_en;
    logic [3:0]  xfer_valve;
`ifdef CHAIN_MIXER_SEQ_ABORT_EN
    logic        abort;
    logic        aborted;
`endif

    int checks;
    int errors;

    logic [3:0] lv [64];
    logic [3:0] me [64];
    logic [3:0] xv [64];
    logic [1:0] st [64];
    logic       dn [64];
    logic       rd [64];
    logic       bz [64];
    logic       ab [64];

    chain_mixer_seq #(
        .NUM_STAGES (4),
        .CNT_W      (16),
        .LOAD_CYCLES(2),
        .XFER_CYCLES(1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mix_cycles(mix_cycles),
        .skip_mask (skip_mask),
`ifdef CHAIN_MIXER_SEQ_ABORT_EN
        .abort     (abort),
        .aborted   (aborted),
`endif
        .ready     (ready),
        .busy      (busy),
        .done      (done),
        .stage     (stage),
        .load_valve(load_valve),
        .mix_en    (mix_en),
        .xfer_valve(xfer_valve)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic begin_run(input logic [15:0] mix, input logic [3:0] skip);
        @(negedge clk);
        mix_cycles = mix;
        skip_mask  = skip;
        start      = 1'b1;
    endtask

    // Samples n cycles at the falling edge; optional pokes happen right after a cycle's sample.
    task automatic capture(input int n, input bit hold, input int poke_at, input int rst_at,
                           input int abort_at);
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            lv[c] = load_valve;
            me[c] = mix_en;
            xv[c] = xfer_valve;
            st[c] = stage;
            dn[c] = done;
            rd[c] = ready;
            bz[c] = busy;
`ifdef CHAIN_MIXER_SEQ_ABORT_EN
            ab[c] = aborted;
            abort = (c == abort_at);
`else
            ab[c] = 1'b0;
`endif
            if (!hold) start = 1'b0;
            if (c == poke_at) begin
                start      = 1'b1;
                mix_cycles = 16'd7;
                skip_mask  = 4'b1111;
            end
            rst = (c == rst_at);
        end
        if (!hold) start = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checks++; if (ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready got %b want 1", ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %b want 0", done); end
        checks++; if (stage !== 2'd0) begin errors++; $display("[TB] FAIL reset_stage got %0d want 0", stage); end
        checks++; if ({load_valve, mix_en, xfer_valve} !== 12'h000) begin
            errors++; $display("[TB] FAIL reset_valves got %h want 000", {load_valve, mix_en, xfer_valve});
        end
    endtask

    task automatic test_basic;
        int n_done, n_busy, n_multi;
        begin_run(16'd3, 4'b0000);
        capture(26, 1'b0, 0, 0, 0);
        n_done = 0; n_busy = 0; n_multi = 0;
        for (int c = 1; c <= 26; c++) begin
            n_done += int'(dn[c]);
            n_busy += int'(bz[c]);
            if ($countones({lv[c], me[c], xv[c]}) > 1) n_multi++;
        end
        checks++; if (lv[1] !== 4'b0001 || lv[2] !== 4'b0001) begin
            errors++; $display("[TB] FAIL basic_load0 got %b %b want 0001 0001", lv[1], lv[2]);
        end
        for (int c = 3; c <= 5; c++) begin
            checks++; if (me[c] !== 4'b0001) begin
                errors++; $display("[TB] FAIL basic_mix0 cycle %0d got %b want 0001", c, me[c]);
            end
        end
        checks++; if (xv[6] !== 4'b0001) begin errors++; $display("[TB] FAIL basic_xfer0 got %b want 0001", xv[6]); end
        checks++; if (lv[7] !== 4'b0010) begin errors++; $display("[TB] FAIL basic_load1 got %b want 0010", lv[7]); end
        checks++; if (xv[24] !== 4'b1000 || st[24] !== 2'd3) begin
            errors++; $display("[TB] FAIL basic_xfer3 got %b stage %0d want 1000 stage 3", xv[24], st[24]);
        end
        checks++; if (dn[25] !== 1'b1) begin errors++; $display("[TB] FAIL basic_done25 got %b want 1", dn[25]); end
        checks++; if (n_done != 1) begin errors++; $display("[TB] FAIL basic_done_count got %0d want 1", n_done); end
        checks++; if (rd[25] !== 1'b0 || rd[26] !== 1'b1) begin
            errors++; $display("[TB] FAIL basic_ready got %b%b want 01", rd[25], rd[26]);
        end
        checks++; if (n_busy != 24) begin errors++; $display("[TB] FAIL basic_busy_cycles got %0d want 24", n_busy); end
        checks++; if (n_multi != 0) begin errors++; $display("[TB] FAIL basic_onehot got %0d multi-hot cycles want 0", n_multi); end
    endtask

    task automatic test_skip;
        begin_run(16'd3, 4'b0101);
        capture(16, 1'b0, 0, 0, 0);
        checks++; if (xv[1] !== 4'b0001 || lv[1] !== 4'b0000) begin
            errors++; $display("[TB] FAIL skip_stage0 got xfer %b load %b want 0001 0000", xv[1], lv[1]);
        end
        checks++; if (lv[2] !== 4'b0010) begin errors++; $display("[TB] FAIL skip_load1 got %b want 0010", lv[2]); end
        checks++; if (xv[7] !== 4'b0010) begin errors++; $display("[TB] FAIL skip_xfer1 got %b want 0010", xv[7]); end
        checks++; if (xv[8] !== 4'b0100 || lv[8] !== 4'b0000) begin
            errors++; $display("[TB] FAIL skip_stage2 got xfer %b load %b want 0100 0000", xv[8], lv[8]);
        end
        checks++; if (lv[9] !== 4'b1000) begin errors++; $display("[TB] FAIL skip_load3 got %b want 1000", lv[9]); end
        checks++; if (xv[14] !== 4'b1000) begin errors++; $display("[TB] FAIL skip_xfer3 got %b want 1000", xv[14]); end
        checks++; if (dn[14] !== 1'b0 || dn[15] !== 1'b1 || rd[16] !== 1'b1) begin
            errors++; $display("[TB] FAIL skip_done got d14=%b d15=%b r16=%b want 0 1 1", dn[14], dn[15], rd[16]);
        end
    endtask

    task automatic test_mix_zero;
        int n_mix;
        begin_run(16'd0, 4'b0000);
        capture(14, 1'b0, 0, 0, 0);
        n_mix = 0;
        for (int c = 1; c <= 14; c++) if (me[c] !== 4'b0000) n_mix++;
        checks++; if (lv[2] !== 4'b0001 || xv[3] !== 4'b0001) begin
            errors++; $display("[TB] FAIL mix0_stage0 got load %b xfer %b want 0001 0001", lv[2], xv[3]);
        end
        checks++; if (lv[4] !== 4'b0010) begin errors++; $display("[TB] FAIL mix0_load1 got %b want 0010", lv[4]); end
        checks++; if (n_mix != 0) begin errors++; $display("[TB] FAIL mix0_no_mix got %0d cycles want 0", n_mix); end
        checks++; if (xv[12] !== 4'b1000 || dn[13] !== 1'b1) begin
            errors++; $display("[TB] FAIL mix0_done got xfer12 %b done13 %b want 1000 1", xv[12], dn[13]);
        end
    endtask

    task automatic test_mid_run_changes;
        int n_done;
        begin_run(16'd3, 4'b0000);
        capture(26, 1'b0, 4, 0, 0);
        mix_cycles = 16'd3;
        skip_mask  = 4'b0000;
        n_done = 0;
        for (int c = 1; c <= 26; c++) n_done += int'(dn[c]);
        checks++; if (lv[7] !== 4'b0010) begin errors++; $display("[TB] FAIL midrun_load1 got %b want 0010", lv[7]); end
        checks++; if (me[11] !== 4'b0010 || me[12] !== 4'b0000 || xv[12] !== 4'b0010) begin
            errors++; $display("[TB] FAIL midrun_mix1 got me11 %b me12 %b xv12 %b want 0010 0000 0010",
                               me[11], me[12], xv[12]);
        end
        checks++; if (dn[25] !== 1'b1 || n_done != 1) begin
            errors++; $display("[TB] FAIL midrun_done got done25 %b count %0d want 1 1", dn[25], n_done);
        end
    endtask

    task automatic test_reset_mid_run;
        int n_done;
        begin_run(16'd3, 4'b0000);
        capture(20, 1'b0, 0, 16, 0);
        n_done = 0;
        for (int c = 17; c <= 20; c++) n_done += int'(dn[c]);
        checks++; if (me[16] !== 4'b0100 || st[16] !== 2'd2) begin
            errors++; $display("[TB] FAIL rstmid_pre got mix %b stage %0d want 0100 2", me[16], st[16]);
        end
        checks++; if (rd[17] !== 1'b1 || bz[17] !== 1'b0 || dn[17] !== 1'b0 || st[17] !== 2'd0) begin
            errors++; $display("[TB] FAIL rstmid_ctrl got ready %b busy %b done %b stage %0d want 1 0 0 0",
                               rd[17], bz[17], dn[17], st[17]);
        end
        checks++; if ({lv[17], me[17], xv[17]} !== 12'h000) begin
            errors++; $display("[TB] FAIL rstmid_valves got %h want 000", {lv[17], me[17], xv[17]});
        end
        checks++; if (n_done != 0 || rd[20] !== 1'b1) begin
            errors++; $display("[TB] FAIL rstmid_after got done count %0d ready %b want 0 1", n_done, rd[20]);
        end
    endtask

    task automatic test_back_to_back;
        int n_done;
        int waited;
        begin_run(16'd0, 4'b0000);
        capture(15, 1'b1, 0, 0, 0);
        start = 1'b0;
        n_done = 0;
        for (int c = 1; c <= 14; c++) n_done += int'(dn[c]);
        checks++; if (dn[13] !== 1'b1 || n_done != 1) begin
            errors++; $display("[TB] FAIL b2b_first_done got done13 %b count %0d want 1 1", dn[13], n_done);
        end
        checks++; if (rd[14] !== 1'b1 || bz[14] !== 1'b0) begin
            errors++; $display("[TB] FAIL b2b_gap got ready %b busy %b want 1 0", rd[14], bz[14]);
        end
        checks++; if (lv[15] !== 4'b0001) begin errors++; $display("[TB] FAIL b2b_restart got %b want 0001", lv[15]); end
        waited = 0;
        while (ready !== 1'b1 && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        checks++; if (ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_timeout ready %b after %0d cycles want 1", ready, waited); end
    endtask

`ifdef CHAIN_MIXER_SEQ_ABORT_EN
    task automatic test_abort;
        int n_done;
        int n_load2;
        int waited;
        begin_run(16'd3, 4'b0000);
        capture(30, 1'b0, 0, 0, 12);
        n_done = 0; n_load2 = 0;
        for (int c = 13; c <= 30; c++) begin
            n_done += int'(dn[c]);
            if (lv[c][2] !== 1'b0) n_load2++;
        end
        checks++; if (xv[12] !== 4'b0010 || ab[12] !== 1'b0) begin
            errors++; $display("[TB] FAIL abort_pre got xfer %b aborted %b want 0010 0", xv[12], ab[12]);
        end
        checks++; if (rd[13] !== 1'b1 || ab[13] !== 1'b1 || {lv[13], me[13], xv[13]} !== 12'h000) begin
            errors++; $display("[TB] FAIL abort_idle got ready %b aborted %b valves %h want 1 1 000",
                               rd[13], ab[13], {lv[13], me[13], xv[13]});
        end
        checks++; if (n_done != 0 || n_load2 != 0) begin
            errors++; $display("[TB] FAIL abort_quiet got done %0d load2 %0d want 0 0", n_done, n_load2);
        end
        begin_run(16'd0, 4'b0000);
        capture(2, 1'b0, 0, 0, 0);
        checks++; if (ab[1] !== 1'b0 || lv[1] !== 4'b0001) begin
            errors++; $display("[TB] FAIL abort_clear got aborted %b load %b want 0 0001", ab[1], lv[1]);
        end
        waited = 0;
        while (ready !== 1'b1 && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        checks++; if (ready !== 1'b1) begin errors++; $display("[TB] FAIL abort_timeout ready %b want 1", ready); end
    endtask
`endif

    initial begin
        checks     = 0;
        errors     = 0;
        rst        = 1'b1;
        start      = 1'b0;
        mix_cycles = 16'd0;
        skip_mask  = 4'b0000;
`ifdef CHAIN_MIXER_SEQ_ABORT_EN
        abort      = 1'b0;
`endif
        test_reset();
        test_basic();
        test_skip();
        test_mix_zero();
        test_mid_run_changes();
        test_reset_mid_run();
        test_back_to_back();
`ifdef CHAIN_MIXER_SEQ_ABORT_EN
        test_abort();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
